nco_sweep_ctrl: RTL and testbench
=================================

// Module: nco_sweep_ctrl
// PURPOSE
//  Frequency-sweep sequencer that drives the step and active-high sync reset inputs of the phase-accumulator NCO.
//  On a start pulse it produces a stepped linear chirp on step (f_start -> f_stop), holding each value for a
//  programmable dwell. Sweeps are single-shot or continuous triangle. Sits between the control registers and the NCO.
// PARAMETERS
//  STEP_SIZE   16  width of frequency step words; must match NCO STEP_SIZE
//  DWELL_WIDTH 16  width of the per-step dwell counter
// PORTS
//  clk      in   1            system clock, rising edge
//  rst      in   1            asynchronous, active-low reset
//  start    in   1            sweep request; sampled only in IDLE
//  abort    in   1            stop sweep immediately; priority over start
//  mode     in   1            0 = single sweep, 1 = continuous triangle; latched on start
//  f_start  in   STEP_SIZE    first step value (unsigned); latched on start
//  f_stop   in   STEP_SIZE    last/upper step value (unsigned); latched on start
//  f_inc    in   STEP_SIZE    increment per dwell (unsigned); latched on start
//  dwell    in   DWELL_WIDTH  each step value is held dwell+1 cycles; latched on start
//  step     out  STEP_SIZE    registered NCO step word
//  nco_rst  out  1            registered, active-high; drives NCO rst
//  busy     out  1            high while sweep in progress
//  done     out  1            one-cycle pulse at end of single sweep
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, step=0, nco_rst=1, busy=0, done=0, config regs=0.
//  States: IDLE, UP, DOWN, DONE. All outputs registered; config inputs ignored outside start acceptance.
//  IDLE: start=1 & abort=0 -> latch config; next edge: step=f_start, nco_rst=0, busy=1, dwell cnt=dwell, -> UP.
//    start while busy or in DONE is ignored (no queueing). IDLE holds step and nco_rst at prior values.
//  Dwell: counter decrements each cycle; step updates on the cycle counter==0, then reloads dwell.
//    Therefore every step value, including the first and the endpoints, is visible for exactly dwell+1 cycles.
//  UP, dwell expiry:
//    If step==f_stop: mode0 -> DONE; mode1 -> DOWN with step=max(f_stop-f_inc, f_start).
//    Otherwise step=min(step+f_inc, f_stop). The sum is computed in STEP_SIZE+1 bits, so there is no wrap-around.
//  DOWN, dwell expiry:
//    If step==f_start: -> UP with step=min(f_start+f_inc, f_stop).
//    Otherwise step=max(step-f_inc, f_start). Computed without underflow.
//  DONE: lasts one cycle, done=1, busy=0, step holds f_stop, nco_rst stays 0 (tone continues) -> IDLE.
//  Degenerate configs:
//    f_inc==0 -> start is ignored (stays IDLE, no busy, no done).
//    f_start>=f_stop -> single point: step=f_start for dwell+1 cycles, then DONE regardless of mode.
//  abort (any state, incl. coincident with dwell expiry or start): next edge -> IDLE.
//    Also step=0, nco_rst=1, busy=0, done=0; no done pulse is generated.
//  Async reset mid-sweep: immediate reset values, no done.
//  Latency: start edge to first step=f_start is 1 cycle; done asserts the cycle after the last f_stop dwell cycle.
// TESTING
//  1. Reset: rst=0 mid-run -> step=0, nco_rst=1, busy=0, done=0 asynchronously.
//  2. Single sweep: f_start=100, f_stop=130, f_inc=10, dwell=2, mode=0, start pulse ->
//     step 100,100,100,110x3,120x3,130x3; busy for 12 cycles; then done one cycle; step stays 130.
//  3. Saturation: f_start=0, f_stop=25, f_inc=10, dwell=0 -> step 0,10,20,25 then done.
//     With f_stop=16'hFFFF, f_inc=16'h8000 -> 0,8000,FFFF, with no wrap.
//  4. Triangle: f_start=10, f_stop=30, f_inc=10, dwell=0, mode=1 -> 10,20,30,20,10,20,30,... with no done.
//     abort -> next cycle step=0, nco_rst=1, busy=0.
//  5. Boundaries: start with f_inc=0 -> no busy. f_start=50, f_stop=40 -> step=50 for dwell+1 cycles, then done.
//     start+abort in same cycle -> stays IDLE. start during busy -> ignored.
//  6. Config isolation: change f_stop/dwell mid-sweep -> sweep profile unchanged from latched values.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - stepped linear chirp sequencer driving the NCO step word and sync reset
module nco_sweep_ctrl #(
  parameter int STEP_SIZE   = 16,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   mode,
  input  logic [STEP_SIZE-1:0]   f_start,
  input  logic [STEP_SIZE-1:0]   f_stop,
  input  logic [STEP_SIZE-1:0]   f_inc,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [STEP_SIZE-1:0]   step,
  output logic                   nco_rst,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

  state_t                 state;
  logic                   mode_q;
  logic [STEP_SIZE-1:0]   f_start_q;
  logic [STEP_SIZE-1:0]   f_stop_q;
  logic [STEP_SIZE-1:0]   f_inc_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [DWELL_WIDTH-1:0] cnt;

  // Next step candidates. The sum carries one extra bit so a large increment
  // saturates at f_stop instead of wrapping. The downward step compares the
  // distance above f_start against the increment, so it never underflows.
  // Both are only used while step lies within [f_start, f_stop].
  logic [STEP_SIZE:0]   up_sum;
  logic [STEP_SIZE-1:0] step_up;
  logic [STEP_SIZE-1:0] step_dn;
  logic                 single_pt;
  logic                 expire;

  assign up_sum    = {1'b0, step} + {1'b0, f_inc_q};
  assign step_up   = (up_sum >= {1'b0, f_stop_q}) ? f_stop_q : up_sum[STEP_SIZE-1:0];
  assign step_dn   = ((step - f_start_q) <= f_inc_q) ? f_start_q : (step - f_inc_q);
  assign single_pt = (f_start_q >= f_stop_q);
  assign expire    = (cnt == '0);

  // Sweep state machine; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      step      <= '0;
      nco_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      mode_q    <= 1'b0;
      f_start_q <= '0;
      f_stop_q  <= '0;
      f_inc_q   <= '0;
      dwell_q   <= '0;
      cnt       <= '0;
    end else if (abort) begin
      state   <= IDLE;
      step    <= '0;
      nco_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // A zero increment could never reach f_stop, so such a request is dropped.
          if (start && (f_inc != '0)) begin
            mode_q    <= mode;
            f_start_q <= f_start;
            f_stop_q  <= f_stop;
            f_inc_q   <= f_inc;
            dwell_q   <= dwell;
            step      <= f_start;
            nco_rst   <= 1'b0;
            busy      <= 1'b1;
            cnt       <= dwell;
            state     <= UP;
          end
        end
        UP: begin
          if (expire) begin
            cnt <= dwell_q;
            // step >= f_stop also covers the single-point case f_start >= f_stop.
            if (step >= f_stop_q) begin
              if (mode_q && !single_pt) begin
                step  <= step_dn;
                state <= DOWN;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              step <= step_up;
            end
          end else begin
            cnt <= cnt - DWELL_WIDTH'(1);
          end
        end
        DOWN: begin
          if (expire) begin
            cnt <= dwell_q;
            if (step == f_start_q) begin
              step  <= step_up;
              state <= UP;
            end else begin
              step <= step_dn;
            end
          end else begin
            cnt <= cnt - DWELL_WIDTH'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - self-checking bench for nco_sweep_ctrl
module tb_nco_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        mode;
  logic [15:0] f_start;
  logic [15:0] f_stop;
  logic [15:0] f_inc;
  logic [15:0] dwell;
  logic [15:0] step;
  logic        nco_rst;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] step;
    logic        busy;
    logic        done;
    logic        nco_rst;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  exp_t rst_e;

  nco_sweep_ctrl #(.STEP_SIZE(16), .DWELL_WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .f_start (f_start),
    .f_stop  (f_stop),
    .f_inc   (f_inc),
    .dwell   (dwell),
    .step    (step),
    .nco_rst (nco_rst),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sweep model: list the step values the sweep visits, each held dwell+1 cycles.
  task automatic model_sweep(input logic m, input logic [15:0] fs, input logic [15:0] fe,
                             input logic [15:0] fi, input logic [15:0] dw, input int ncyc);
    longint p, s, e, inc;
    bit     up, fin;
    int     n;
    exp_t   x;
    s = fs; e = fe; inc = fi; p = s; up = 1; fin = 0; n = 0;
    if (inc == 0) return;
    while (!fin && n < ncyc) begin
      for (int k = 0; k <= int'(dw); k++) begin
        x.step = p[15:0]; x.busy = 1'b1; x.done = 1'b0; x.nco_rst = 1'b0;
        exp_q.push_back(x);
        n++;
      end
      if (s >= e || (!m && p == e)) begin
        fin = 1;
        x.busy = 1'b0; x.done = 1'b1;
        exp_q.push_back(x);
      end else if (up) begin
        if (p == e) begin up = 0; p = (e - inc > s) ? e - inc : s; end
        else p = (p + inc < e) ? p + inc : e;
      end else begin
        if (p == s) begin up = 1; p = (s + inc < e) ? s + inc : e; end
        else p = (p - inc > s) ? p - inc : s;
      end
    end
  endtask

  // Model advances on each clock edge; when idle it holds step/nco_rst.
  always @(posedge clk) begin
    if (rst) begin
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else begin cur.busy = 1'b0; cur.done = 1'b0; end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("step",    32'(step),    32'(cur.step));
    chk("busy",    32'(busy),    32'(cur.busy));
    chk("done",    32'(done),    32'(cur.done));
    chk("nco_rst", 32'(nco_rst), 32'(cur.nco_rst));
  end

  task automatic do_start(input logic m, input logic [15:0] fs, input logic [15:0] fe,
                          input logic [15:0] fi, input logic [15:0] dw, input logic ab,
                          input int ncyc);
    exp_t a;
    @(negedge clk); #1;
    mode = m; f_start = fs; f_stop = fe; f_inc = fi; dwell = dw;
    start = 1'b1; abort = ab;
    if (ab) begin
      a = '{16'h0, 1'b0, 1'b0, 1'b1};
      exp_q.delete();
      exp_q.push_back(a);
    end else if (exp_q.size() == 0 && !cur.busy && !cur.done) begin
      model_sweep(m, fs, fe, fi, dw, ncyc);
    end
    @(negedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic do_abort();
    exp_t a;
    @(negedge clk); #1;
    abort = 1'b1;
    a = '{16'h0, 1'b0, 1'b0, 1'b1};
    exp_q.delete();
    exp_q.push_back(a);
    @(negedge clk); #1;
    abort = 1'b0;
  endtask

  initial begin
    rst_e = '{16'h0, 1'b0, 1'b0, 1'b1};
    cur = rst_e;
    rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    f_start = '0; f_stop = '0; f_inc = '0; dwell = '0;
    #12;
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_nco",  32'(nco_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk); #1 rst = 1'b1;

    // single sweep 100..130 by 10, dwell 2
    do_start(1'b0, 16'd100, 16'd130, 16'd10, 16'd2, 1'b0, 100);
    chk("t2_first", 32'(step), 32'd100);
    repeat (3) @(negedge clk);
    chk("t2_110", 32'(step), 32'd110);
    repeat (8) @(negedge clk);
    chk("t2_last", 32'(step), 32'd130);
    chk("t2_last_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_done_busy", 32'(busy), 32'd0);
    chk("t2_done_step", 32'(step), 32'd130);
    @(negedge clk);
    chk("t2_after_done", 32'(done), 32'd0);
    chk("t2_hold_step", 32'(step), 32'd130);
    chk("t2_hold_nco", 32'(nco_rst), 32'd0);

    // saturation at f_stop
    do_start(1'b0, 16'd0, 16'd25, 16'd10, 16'd0, 1'b0, 100);
    chk("t3_0", 32'(step), 32'd0);
    @(negedge clk); chk("t3_10", 32'(step), 32'd10);
    @(negedge clk); chk("t3_20", 32'(step), 32'd20);
    @(negedge clk); chk("t3_25", 32'(step), 32'd25);
    @(negedge clk); chk("t3_done", 32'(done), 32'd1);

    // no wrap near full scale
    do_start(1'b0, 16'h0000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 100);
    chk("t3w_0", 32'(step), 32'h0);
    @(negedge clk); chk("t3w_8000", 32'(step), 32'h8000);
    @(negedge clk); chk("t3w_ffff", 32'(step), 32'hFFFF);
    @(negedge clk); chk("t3w_done", 32'(done), 32'd1);

    // continuous triangle 10..30
    do_start(1'b1, 16'd10, 16'd30, 16'd10, 16'd0, 1'b0, 60);
    chk("t4_10", 32'(step), 32'd10);
    @(negedge clk); chk("t4_20", 32'(step), 32'd20);
    @(negedge clk); chk("t4_30", 32'(step), 32'd30);
    @(negedge clk); chk("t4_20d", 32'(step), 32'd20);
    @(negedge clk); chk("t4_10d", 32'(step), 32'd10);
    @(negedge clk); chk("t4_20u", 32'(step), 32'd20);
    @(negedge clk); chk("t4_30u", 32'(step), 32'd30);
    repeat (5) @(negedge clk);
    do_abort();
    chk("t4_ab_step", 32'(step), 32'd0);
    chk("t4_ab_nco",  32'(nco_rst), 32'd1);
    chk("t4_ab_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // triangle with non-aligned endpoints and dwell 1
    do_start(1'b1, 16'd5, 16'd27, 16'd10, 16'd1, 1'b0, 80);
    repeat (25) @(negedge clk);
    do_abort();

    // zero increment is ignored
    do_start(1'b0, 16'd10, 16'd20, 16'd0, 16'd0, 1'b0, 100);
    chk("t5_inc0_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("t5_inc0_busy2", 32'(busy), 32'd0);

    // f_start > f_stop: single point then done, even in triangle mode
    do_start(1'b1, 16'd50, 16'd40, 16'd5, 16'd3, 1'b0, 100);
    chk("t5_pt_first", 32'(step), 32'd50);
    repeat (3) @(negedge clk);
    chk("t5_pt_last", 32'(step), 32'd50);
    chk("t5_pt_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t5_pt_done", 32'(done), 32'd1);
    repeat (2) @(negedge clk);

    // start and abort together
    do_start(1'b0, 16'd1, 16'd9, 16'd1, 16'd0, 1'b1, 100);
    chk("t5_sa_step", 32'(step), 32'd0);
    chk("t5_sa_nco",  32'(nco_rst), 32'd1);
    chk("t5_sa_busy", 32'(busy), 32'd0);

    // start while busy is ignored; config changes mid-sweep have no effect
    do_start(1'b0, 16'd200, 16'd260, 16'd20, 16'd3, 1'b0, 100);
    repeat (2) @(negedge clk);
    #1 f_stop = 16'd1000; dwell = 16'd0; mode = 1'b1;
    do_start(1'b1, 16'd0, 16'd5, 16'd1, 16'd0, 1'b0, 100);
    repeat (20) @(negedge clk);
    chk("t6_end_step", 32'(step), 32'd260);
    chk("t6_end_busy", 32'(busy), 32'd0);

    // asynchronous reset mid-sweep
    do_start(1'b0, 16'd300, 16'd400, 16'd1, 16'd5, 1'b0, 1000);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    cur = rst_e;
    #1;
    chk("t1_step", 32'(step), 32'd0);
    chk("t1_nco",  32'(nco_rst), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    @(negedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
